// File: rtl/conv_out_collector.sv
// conv_out_collector: tags each convolution result with its output-grid
// coordinate, buffers it in a small first-word-fall-through FIFO, and
// re-emits it as a ready/valid stream carrying start/end-of-frame markers.
module conv_out_collector #(
  parameter int DATA_SIZE   = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1,
  parameter int DW          = 32,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_BW      = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_tvalid,
  input  logic          o_tready,
  output logic [DW-1:0] o_tdata,
  output logic          o_tuser,
  output logic          o_tlast,
  output logic          o_frame_done,
  output logic          o_overflow
);

  localparam int OUT_SIZE = (DATA_SIZE - KERNEL_SIZE) / STRIDE + 1;
  localparam int PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [CNT_BW-1:0] LAST_POS = CNT_BW'(OUT_SIZE - 1);
  localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [CNT_BW-1:0] POS_ONE  = CNT_BW'(1);

  // Each entry is {data, sof, eof}.
  logic [DW+1:0] mem [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]    count_reg, count_next;
  logic [CNT_BW-1:0] row_reg, col_reg, row_next, col_next;
  logic              overflow_reg, frame_done_reg;

  logic          full, pop, push, sof, eof, sample;
  logic [DW+1:0] head;

  assign full   = (count_reg == FULL_CNT);
  assign pop    = o_tvalid && o_tready;
  // clr swallows a coincident strobe entirely, so it neither pushes nor
  // advances the coordinate counters.
  assign sample = i_valid && !clr;
  // A full FIFO can still take a sample when the head leaves in the same cycle.
  assign push   = sample && (!full || pop);
  assign sof    = (row_reg == '0) && (col_reg == '0);
  assign eof    = (row_reg == LAST_POS) && (col_reg == LAST_POS);
  assign head   = mem[rd_ptr_reg];

  // Output side reads the head entry directly; idle outputs are forced to zero.
  assign o_tvalid     = (count_reg != '0);
  assign o_tdata      = o_tvalid ? head[DW+1:2] : '0;
  assign o_tuser      = o_tvalid && head[1];
  assign o_tlast      = o_tvalid && head[0];
  assign o_frame_done = frame_done_reg;
  assign o_overflow   = overflow_reg;

  // Next coordinate: raster order, wrapping at the end of each row and frame.
  always_comb begin
    row_next = row_reg;
    col_next = col_reg;
    if (col_reg == LAST_POS) begin
      col_next = '0;
      row_next = (row_reg == LAST_POS) ? '0 : row_reg + POS_ONE;
    end else begin
      col_next = col_reg + POS_ONE;
    end
  end

  // Occupancy update; simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= {i_data, sof, eof};
  end

  // Pointers, occupancy, coordinate counters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      row_reg        <= '0;
      col_reg        <= '0;
      overflow_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      count_reg <= count_next;
      // Counters advance on dropped samples too, keeping tags aligned.
      if (sample) begin
        row_reg <= row_next;
        col_reg <= col_next;
      end
      if (sample && !push) overflow_reg <= 1'b1;
      frame_done_reg <= pop && o_tlast;
    end
  end

endmodule

// File: tb/tb_conv_out_collector.sv
// Testbench for conv_out_collector: a hand-checked vector table, directed
// corner-case sequences, and randomized traffic, all compared every cycle
// against a queue-based reference model.
module tb_conv_out_collector;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int OSZ   = (32 - 5) / 1 + 1;
  localparam int NPIX  = OSZ * OSZ;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_tvalid;
  logic          o_tready = 1'b0;
  logic [DW-1:0] o_tdata;
  logic          o_tuser;
  logic          o_tlast;
  logic          o_frame_done;
  logic          o_overflow;

  conv_out_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_tvalid     (o_tvalid),
    .o_tready     (o_tready),
    .o_tdata      (o_tdata),
    .o_tuser      (o_tuser),
    .o_tlast      (o_tlast),
    .o_frame_done (o_frame_done),
    .o_overflow   (o_overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of expected beats plus a running sample index.
  typedef struct {
    logic [DW-1:0] d;
    bit            sof;
    bit            eof;
  } ent_t;

  ent_t q[$];
  int   m_idx;
  bit   m_ovf;
  bit   m_fd;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_idx = 0;
    m_ovf = 1'b0;
    m_fd  = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".tvalid"}, 64'(o_tvalid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".tdata"}, 64'(o_tdata), 64'(q[0].d));
      chk({tag, ".tuser"}, 64'(o_tuser), 64'(q[0].sof));
      chk({tag, ".tlast"}, 64'(o_tlast), 64'(q[0].eof));
    end
    chk({tag, ".overflow"}, 64'(o_overflow), 64'(m_ovf));
    chk({tag, ".frame_done"}, 64'(o_frame_done), 64'(m_fd));
  endtask

  // One clock: check current outputs, drive inputs, advance the model, and
  // return at the following falling edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic c,
                      input string tag);
    bit   pop;
    ent_t e;
    check_model(tag);
    i_valid  = v;
    i_data   = d;
    o_tready = rdy;
    clr      = c;
    pop = (q.size() != 0) && rdy;
    if (c) begin
      model_reset();
    end else begin
      m_fd = pop && q[0].eof;
      if (v) begin
        if (q.size() < DEPTH || pop) begin
          e.d   = d;
          e.sof = (m_idx == 0);
          e.eof = (m_idx == NPIX - 1);
          q.push_back(e);
        end else begin
          m_ovf = 1'b1;
        end
        m_idx = (m_idx + 1) % NPIX;
      end
      if (pop) void'(q.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Table: inputs applied for one cycle, outputs expected after that edge.
  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    logic          rdy;
    logic          c;
    logic          e_tvalid;
    logic [DW-1:0] e_tdata;
    logic          e_tuser;
    logic          e_ovf;
  } vec_t;

  vec_t tbl[7];
  int   fd_pulses;

  initial begin
    tbl[0] = '{1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'hB, 1'b0, 1'b0, 1'b1, 32'hA, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hB, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 32'hD, 1'b1, 1'b0, 1'b1, 32'hD, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};

    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.tvalid", 64'(o_tvalid), 64'd0);
    chk("reset.tdata", 64'(o_tdata), 64'd0);
    chk("reset.tuser", 64'(o_tuser), 64'd0);
    chk("reset.tlast", 64'(o_tlast), 64'd0);
    chk("reset.frame_done", 64'(o_frame_done), 64'd0);
    chk("reset.overflow", 64'(o_overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table: push, pop, clr discarding a coincident strobe, retag.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rdy, tbl[i].c, "tbl");
      chk($sformatf("tbl%0d.tvalid", i), 64'(o_tvalid), 64'(tbl[i].e_tvalid));
      if (tbl[i].e_tvalid) begin
        chk($sformatf("tbl%0d.tdata", i), 64'(o_tdata), 64'(tbl[i].e_tdata));
        chk($sformatf("tbl%0d.tuser", i), 64'(o_tuser), 64'(tbl[i].e_tuser));
      end
      chk($sformatf("tbl%0d.overflow", i), 64'(o_overflow), 64'(tbl[i].e_ovf));
    end
    step(1'b0, '0, 1'b0, 1'b1, "sync");

    // Single full frame with continuous ready.
    fd_pulses = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0, "frame");
      chk("frame.occupancy_le1", 64'(q.size() <= 1), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "frame_tail");
      if (o_frame_done) fd_pulses++;
    end
    chk("frame.done_pulses", 64'(fd_pulses), 64'd1);
    $display("frame: %0d samples streamed", NPIX);

    // Backpressure: 17 samples into a 16-deep FIFO, then drain, then finish
    // the frame so the next tuser lands where the counters say.
    for (int i = 0; i < 17; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "bp_fill");
    step(1'b0, '0, 1'b0, 1'b0, "bp_hold");
    chk("bp.overflow", 64'(o_overflow), 64'd1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, "bp_drain");
    for (int i = 17; i < NPIX + 3; i++) step(1'b1, DW'(i + 1000), 1'b1, 1'b0, "bp_next");
    $display("backpressure: overflow=%0b", o_overflow);

    // Full FIFO with simultaneous push and pop for 4 cycles.
    step(1'b0, '0, 1'b0, 1'b1, "full_clr");
    for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "full_fill");
    for (int i = 0; i < 4; i++) step(1'b1, DW'(100 + i), 1'b1, 1'b0, "full_pp");
    chk("full.count_kept", 64'(o_tvalid), 64'd1);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1, 1'b0, "full_drain");
    chk("full.no_overflow", 64'(o_overflow), 64'd0);
    $display("full: simultaneous push/pop done");

    // Two frames, sparse input, random ready.
    step(1'b0, '0, 1'b0, 1'b1, "rnd_clr");
    fd_pulses = 0;
    for (int i = 0; i < 2 * NPIX; i++) begin
      step(1'b1, $urandom, 1'($urandom_range(1)), 1'b0, "rnd");
      if (o_frame_done) fd_pulses++;
      step(1'b0, '0, 1'($urandom_range(1)), 1'b0, "rnd");
      if (o_frame_done) fd_pulses++;
    end
    for (int i = 0; i < 40; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "rnd_drain");
      if (o_frame_done) fd_pulses++;
    end
    if (!m_ovf) chk("rnd.done_pulses", 64'(fd_pulses), 64'd2);
    $display("random: %0d frame_done pulses, overflow=%0b", fd_pulses, o_overflow);

    // clr mid-frame with i_valid high in the same cycle.
    for (int i = 0; i < 100; i++) step(1'b1, DW'(i), 1'($urandom_range(1)), 1'b0, "clr_pre");
    step(1'b1, 32'hDEAD, 1'b0, 1'b1, "clr");
    chk("clr.empty", 64'(o_tvalid), 64'd0);
    chk("clr.overflow", 64'(o_overflow), 64'd0);
    step(1'b1, 32'h55, 1'b0, 1'b0, "clr_post");
    chk("clr.retag_tuser", 64'(o_tuser), 64'd1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, "clr_drain");
    $display("clr: mid-frame clear done");

    // Asynchronous reset pulse in the middle of streaming.
    for (int i = 0; i < 50; i++) step(1'b1, DW'(i), 1'b0, 1'b0, "arst_pre");
    i_valid  = 1'b0;
    o_tready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst.tvalid", 64'(o_tvalid), 64'd0);
    chk("arst.tdata", 64'(o_tdata), 64'd0);
    chk("arst.tuser", 64'(o_tuser), 64'd0);
    chk("arst.overflow", 64'(o_overflow), 64'd0);
    chk("arst.frame_done", 64'(o_frame_done), 64'd0);
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    step(1'b1, 32'h77, 1'b0, 1'b0, "arst_post");
    chk("arst.retag_tuser", 64'(o_tuser), 64'd1);
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(1)), $urandom, 1'($urandom_range(1)), 1'b0, "arst_rnd");
    check_model("final");
    $display("reset: async pulse done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
